fwd_scoreboard: RTL and testbench

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard.sv | 232 +++++++++++++++++++++++
 tb/tb_fwd_scoreboard.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
//   Tracks the destination register and remaining result latency (Tnew) of
//   the instructions sitting in the stages after decode. For each source
//   operand of the decode instruction it picks a forwarding stage and raises
//   a stall when the youngest producer of that register cannot deliver in time.
//
//   Optional feature: define SCOREBOARD_MDU_EN to add a multiply/divide busy
//   counter (ports mdu_start, mdu_is_div, mdu_use; parameters MULT_CYC and
//   DIV_CYC) whose busy state also stalls MDU consumers.
//
//   Stage k (1..DEPTH) lives at packed index k-1 of every stage vector.
//   Bubbles carry zero addr/tnew so the exported stage buses read clean.

module fwd_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int NSRC     = 2,
  parameter int AW       = 5,
  parameter int TW       = 2,
`ifdef SCOREBOARD_MDU_EN
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
`endif
  localparam int SW      = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_addr,
  input  logic [TW-1:0]       issue_tnew,
  input  logic [NSRC*AW-1:0]  src_addr,
  input  logic [NSRC*TW-1:0]  src_tuse,
`ifdef SCOREBOARD_MDU_EN
  input  logic                mdu_start,
  input  logic                mdu_is_div,
  input  logic                mdu_use,
`endif
  output logic                stall,
  output logic [NSRC*SW-1:0]  fwd_sel,
  output logic [DEPTH*AW-1:0] stage_addr,
  output logic [DEPTH*TW-1:0] stage_tnew
);

  // Stage entries {valid, addr, tnew}.
  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [DEPTH-1:0][AW-1:0]  addr_q,  addr_d;
  logic [DEPTH-1:0][TW-1:0]  tnew_q,  tnew_d;

  // Per-source match of the youngest producer.
  logic [NSRC-1:0]           hit_s;
  logic [NSRC-1:0][SW-1:0]   hit_stage_s;
  logic [NSRC-1:0][TW-1:0]   hit_tnew_s;

  // Per-source hazard and forwarding decision.
  logic [NSRC-1:0]           hazard_s;
  logic [NSRC-1:0][SW-1:0]   fwd_sel_s;

  logic                      mdu_stall_s;
  logic                      stall_s;
  logic                      load_s;

  // Scan stages oldest to youngest so the last hit written is the youngest one.
  always_comb begin
    hit_s       = {NSRC{1'b0}};
    hit_stage_s = {(NSRC*SW){1'b0}};
    hit_tnew_s  = {(NSRC*TW){1'b0}};
    for (int j = 0; j < NSRC; j++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if ((src_addr[j*AW +: AW] != {AW{1'b0}}) && valid_q[k] &&
            (addr_q[k] == src_addr[j*AW +: AW])) begin
          hit_s[j]       = 1'b1;
          hit_stage_s[j] = SW'(k + 1);
          hit_tnew_s[j]  = tnew_q[k];
        end else begin
          hit_s[j]       = hit_s[j];
          hit_stage_s[j] = hit_stage_s[j];
          hit_tnew_s[j]  = hit_tnew_s[j];
        end
      end
    end
  end

  // A producer still computing blocks the source; a finished one is forwarded.
  // An older finished producer is never used when a younger one matched.
  always_comb begin
    hazard_s  = {NSRC{1'b0}};
    fwd_sel_s = {(NSRC*SW){1'b0}};
    for (int j = 0; j < NSRC; j++) begin
      if (hit_s[j]) begin
        hazard_s[j] = (hit_tnew_s[j] > src_tuse[j*TW +: TW]);
        if (hit_tnew_s[j] == {TW{1'b0}}) begin
          fwd_sel_s[j] = hit_stage_s[j];
        end else begin
          fwd_sel_s[j] = {SW{1'b0}};
        end
      end else begin
        hazard_s[j]  = 1'b0;
        fwd_sel_s[j] = {SW{1'b0}};
      end
    end
  end

`ifdef SCOREBOARD_MDU_EN
  localparam int MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  logic [CW-1:0] busy_q, busy_d;

  // A new MDU op (re)loads the latency; otherwise count down to idle.
  always_comb begin
    busy_d = busy_q;
    if (mdu_start) begin
      if (mdu_is_div) begin
        busy_d = CW'(DIV_CYC);
      end else begin
        busy_d = CW'(MULT_CYC);
      end
    end else if (busy_q != {CW{1'b0}}) begin
      busy_d = busy_q - CW'(1);
    end else begin
      busy_d = {CW{1'b0}};
    end
  end

  // Busy counter register; reset wins over a start in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= {CW{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign mdu_stall_s = mdu_use & ((busy_q != {CW{1'b0}}) | mdu_start);
`else
  assign mdu_stall_s = 1'b0;
`endif

  assign stall_s = (|hazard_s) | mdu_stall_s;
  assign load_s  = ~stall_s & issue_valid & (issue_addr != {AW{1'b0}});

  // Stage 1 takes the issuing instruction or a bubble; older stages shift
  // unconditionally with Tnew counting down to zero. Stage DEPTH falls off.
  always_comb begin
    valid_d = {DEPTH{1'b0}};
    addr_d  = {(DEPTH*AW){1'b0}};
    tnew_d  = {(DEPTH*TW){1'b0}};
    if (load_s) begin
      valid_d[0] = 1'b1;
      addr_d[0]  = issue_addr;
      tnew_d[0]  = issue_tnew;
    end else begin
      valid_d[0] = 1'b0;
      addr_d[0]  = {AW{1'b0}};
      tnew_d[0]  = {TW{1'b0}};
    end
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      addr_d[k]  = addr_q[k-1];
      if (tnew_q[k-1] != {TW{1'b0}}) begin
        tnew_d[k] = tnew_q[k-1] - TW'(1);
      end else begin
        tnew_d[k] = {TW{1'b0}};
      end
    end
  end

  // Stage registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= {DEPTH{1'b0}};
      addr_q  <= {(DEPTH*AW){1'b0}};
      tnew_q  <= {(DEPTH*TW){1'b0}};
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      tnew_q  <= tnew_d;
    end
  end

  assign stall      = stall_s;
  assign fwd_sel    = fwd_sel_s;
  assign stage_addr = addr_q;
  assign stage_tnew = tnew_q;

  fwd_scoreboard_checker #(
    .DEPTH (DEPTH),
    .NSRC  (NSRC),
    .SW    (SW)
  ) u_checker (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall_s),
    .stage_valid (valid_q),
    .fwd_sel     (fwd_sel_s),
    .hazard      (hazard_s)
  );

endmodule

// fwd_scoreboard_checker
//   Structural invariants of the scoreboard, kept apart from the datapath.
module fwd_scoreboard_checker #(
  parameter int DEPTH = 3,
  parameter int NSRC  = 2,
  parameter int SW    = 2
) (
  input logic                clk,
  input logic                reset,
  input logic                stall,
  input logic [DEPTH-1:0]    stage_valid,
  input logic [NSRC*SW-1:0]  fwd_sel,
  input logic [NSRC-1:0]     hazard
);

  // A stalled cycle always leaves a bubble in stage 1.
  a_stall_bubble: assert property (@(posedge clk) disable iff (reset)
    stall |=> !stage_valid[0]);

  // Reset empties every stage.
  a_reset_clear: assert property (@(posedge clk)
    reset |=> (stage_valid == {DEPTH{1'b0}}));

  for (genvar j = 0; j < NSRC; j++) begin : g_src
    // Only stages that exist can be selected.
    a_sel_range: assert property (@(posedge clk)
      fwd_sel[j*SW +: SW] <= SW'(DEPTH));
    // A forwarded source is by definition ready, so it cannot be hazarding.
    a_fwd_no_hazard: assert property (@(posedge clk)
      (fwd_sel[j*SW +: SW] != {SW{1'b0}}) |-> !hazard[j]);
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed vectors with literal expectations, plus
// a per-cycle comparison against a model that tracks in-flight instructions
// by the cycle they were issued (stage = age, tnew = issued tnew - (age-1)).
`timescale 1ns/1ps
module tb_fwd_scoreboard;
  localparam int DEPTH = 3;
  localparam int NSRC  = 2;
  localparam int AW    = 5;
  localparam int TW    = 2;
  localparam int SW    = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                issue_valid;
  logic [AW-1:0]       issue_addr;
  logic [TW-1:0]       issue_tnew;
  logic [NSRC*AW-1:0]  src_addr;
  logic [NSRC*TW-1:0]  src_tuse;
`ifdef SCOREBOARD_MDU_EN
  logic                mdu_start;
  logic                mdu_is_div;
  logic                mdu_use;
`endif
  logic                stall;
  logic [NSRC*SW-1:0]  fwd_sel;
  logic [DEPTH*AW-1:0] stage_addr;
  logic [DEPTH*TW-1:0] stage_tnew;

  always #5 clk = ~clk;

  fwd_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_tnew  (issue_tnew),
    .src_addr    (src_addr),
    .src_tuse    (src_tuse),
`ifdef SCOREBOARD_MDU_EN
    .mdu_start   (mdu_start),
    .mdu_is_div  (mdu_is_div),
    .mdu_use     (mdu_use),
`endif
    .stall       (stall),
    .fwd_sel     (fwd_sel),
    .stage_addr  (stage_addr),
    .stage_tnew  (stage_tnew)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [AW-1:0] addr;
    int            tnew;
    int            icyc;
  } ent_t;
  ent_t q[$];

`ifdef SCOREBOARD_MDU_EN
  int mdu_s   = -1000;
  int mdu_len = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Youngest in-flight producer of register a during the current cycle.
  function automatic void youngest(input logic [AW-1:0] a, output bit hit,
                                   output int stg, output int tn);
    int s;
    hit = 1'b0; stg = 0; tn = 0;
    foreach (q[i]) begin
      s = cyc - q[i].icyc;
      if (a != '0 && q[i].addr == a && s >= 1 && s <= DEPTH && (!hit || s < stg)) begin
        hit = 1'b1;
        stg = s;
        tn  = (q[i].tnew > s - 1) ? q[i].tnew - (s - 1) : 0;
      end
    end
  endfunction

  function automatic bit model_stall();
    bit h; int s; int t; bit st;
    st = 1'b0;
    for (int j = 0; j < NSRC; j++) begin
      youngest(src_addr[j*AW +: AW], h, s, t);
      if (h && t > int'(src_tuse[j*TW +: TW])) st = 1'b1;
    end
`ifdef SCOREBOARD_MDU_EN
    if (mdu_use && ((cyc > mdu_s && cyc <= mdu_s + mdu_len) || mdu_start)) st = 1'b1;
`endif
    return st;
  endfunction

  function automatic logic [NSRC*SW-1:0] model_fwd();
    bit h; int s; int t; logic [NSRC*SW-1:0] f;
    f = '0;
    for (int j = 0; j < NSRC; j++) begin
      youngest(src_addr[j*AW +: AW], h, s, t);
      if (h && t == 0) f[j*SW +: SW] = SW'(s);
    end
    return f;
  endfunction

  // Model advance on each active edge.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
`ifdef SCOREBOARD_MDU_EN
      mdu_s = -1000;
`endif
    end else begin
      if (!model_stall() && issue_valid && issue_addr != '0)
        q.push_back('{issue_addr, int'(issue_tnew), cyc});
`ifdef SCOREBOARD_MDU_EN
      if (mdu_start) begin
        mdu_s   = cyc;
        mdu_len = mdu_is_div ? 10 : 5;
      end
`endif
    end
    cyc = cyc + 1;
    for (int i = q.size() - 1; i >= 0; i--)
      if (cyc - q[i].icyc > DEPTH) q.delete(i);
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("model_stall", 32'(stall), 32'(model_stall()));
      check("model_fwd_sel", 32'(fwd_sel), 32'(model_fwd()));
      for (int k = 1; k <= DEPTH; k++) begin
        foreach (q[i]) begin
          if (cyc - q[i].icyc == k) begin
            check($sformatf("model_stage%0d_addr", k),
                  32'(stage_addr[(k-1)*AW +: AW]), 32'(q[i].addr));
            check($sformatf("model_stage%0d_tnew", k),
                  32'(stage_tnew[(k-1)*TW +: TW]),
                  32'((q[i].tnew > k - 1) ? q[i].tnew - (k - 1) : 0));
          end
        end
      end
    end
  end

  task automatic drive(input bit iv, input int ia, input int it,
                       input int s0, input int t0, input int s1, input int t1);
    issue_valid = iv;
    issue_addr  = AW'(ia);
    issue_tnew  = TW'(it);
    src_addr    = {AW'(s1), AW'(s0)};
    src_tuse    = {TW'(t1), TW'(t0)};
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    repeat (n) next();
  endtask

`ifdef SCOREBOARD_MDU_EN
  task automatic mdu_run(input bit is_div, input int exp_cycles, input string name);
    int cnt;
    bit seen;
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    mdu_start = 1'b1; mdu_is_div = is_div; mdu_use = 1'b0;
    next();
    mdu_start = 1'b0; mdu_use = 1'b1;
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall) begin
        cnt++; seen = 1'b1;
      end else if (seen || i > 0) begin
        break;
      end
      next();
    end
    check(name, 32'(cnt), 32'(exp_cycles));
    next();
    mdu_use = 1'b0;
    idle(2);
  endtask
`endif

  initial begin
    int cnt;
    reset = 1'b1;
    drive(1'b0, 0, 0, 0, 0, 0, 0);
`ifdef SCOREBOARD_MDU_EN
    mdu_start = 1'b0; mdu_is_div = 1'b0; mdu_use = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Post-reset state.
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_fwd_sel", 32'(fwd_sel), 32'd0);
    check("rst_stage_addr", 32'(stage_addr), 32'd0);
    check("rst_stage_tnew", 32'(stage_tnew), 32'd0);
    next();

    // Producer of r8 with tnew 2, consumer needs it at once.
    drive(1'b1, 8, 2, 0, 0, 0, 0);
    next();
    drive(1'b0, 0, 0, 8, 0, 0, 0);
    @(negedge clk); check("r8_stall_c1", 32'(stall), 32'd1);
    next();
    @(negedge clk); check("r8_stall_c2", 32'(stall), 32'd1);
    next();
    @(negedge clk);
    check("r8_stall_c3", 32'(stall), 32'd0);
    check("r8_fwd_stage3", 32'(fwd_sel), 32'd3);
    next();
    idle(4);

    // Producer of r9 with tnew 1, consumed on src1 with tuse 1.
    drive(1'b1, 9, 1, 0, 0, 0, 0);
    next();
    drive(1'b0, 0, 0, 0, 0, 9, 1);
    @(negedge clk);
    check("r9_stall", 32'(stall), 32'd0);
    check("r9_fwd_sel", 32'(fwd_sel), 32'd0);
    next();
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("r9_stage2_addr", 32'(stage_addr[2*AW-1:AW]), 32'd9);
    check("r9_stage2_tnew", 32'(stage_tnew[2*TW-1:TW]), 32'd0);
    next();
    idle(4);

    // Younger r5 not ready shadows an older ready r5.
    drive(1'b1, 5, 1, 0, 0, 0, 0);
    next();
    drive(1'b1, 5, 1, 0, 0, 0, 0);
    next();
    drive(1'b0, 0, 0, 5, 0, 0, 0);
    @(negedge clk);
    check("r5_stage1_addr", 32'(stage_addr[AW-1:0]), 32'd5);
    check("r5_stage2_tnew", 32'(stage_tnew[2*TW-1:TW]), 32'd0);
    check("r5_younger_stall", 32'(stall), 32'd1);
    check("r5_no_old_fwd", 32'(fwd_sel), 32'd0);
    next();
    @(negedge clk);
    check("r5_then_fwd_stage2", 32'(fwd_sel), 32'd2);
    check("r5_then_no_stall", 32'(stall), 32'd0);
    next();
    idle(4);

    // Register zero never tracked nor matched.
    drive(1'b1, 0, 2, 0, 0, 0, 0);
    next();
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("r0_stall", 32'(stall), 32'd0);
    check("r0_fwd_sel", 32'(fwd_sel), 32'd0);
    next();
    idle(4);

    // Both sources forwarded from different stages.
    drive(1'b1, 4, 0, 0, 0, 0, 0);
    next();
    drive(1'b1, 6, 0, 0, 0, 0, 0);
    next();
    drive(1'b0, 0, 0, 4, 0, 6, 0);
    @(negedge clk);
    check("dual_fwd_sel", 32'(fwd_sel), 32'd6);
    check("dual_stall", 32'(stall), 32'd0);
    next();
    idle(4);

    // Hazard only on src1, covered after one cycle by tuse 1.
    drive(1'b1, 7, 2, 0, 0, 0, 0);
    next();
    drive(1'b0, 0, 0, 3, 0, 7, 1);
    @(negedge clk); check("r7_src1_stall", 32'(stall), 32'd1);
    next();
    @(negedge clk); check("r7_src1_release", 32'(stall), 32'd0);
    next();
    idle(4);

    // Instruction reading its own destination against an older writer.
    drive(1'b1, 12, 3, 0, 0, 0, 0);
    next();
    drive(1'b1, 12, 1, 12, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!stall) break;
      cnt++;
      next();
    end
    check("self_match_stall_cycles", 32'(cnt), 32'd3);
    next();
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("self_match_issued_addr", 32'(stage_addr[AW-1:0]), 32'd12);
    check("self_match_issued_tnew", 32'(stage_tnew[TW-1:0]), 32'd1);
    next();
    idle(4);

    // Reset in the middle of a stall.
    drive(1'b1, 8, 2, 0, 0, 0, 0);
    next();
    drive(1'b0, 0, 0, 8, 0, 0, 0);
    @(negedge clk); check("rst_mid_pre_stall", 32'(stall), 32'd1);
    next();
    reset = 1'b1;
    next();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_fwd", 32'(fwd_sel), 32'd0);
    check("rst_mid_stage_addr", 32'(stage_addr), 32'd0);
    check("rst_mid_stage_tnew", 32'(stage_tnew), 32'd0);
    next();
    idle(4);

`ifdef SCOREBOARD_MDU_EN
    mdu_run(1'b0, 5, "mdu_mult_stall_cycles");
    mdu_run(1'b1, 10, "mdu_div_stall_cycles");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
